// File: rtl/pattern_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pattern_pkg
//  Brief    : Shared encodings and default widths for the pattern-match
//             window reporting path.
//  Revision : 1.0 - initial release
// ============================================================================
package pattern_pkg;

  // Window reporter FSM encoding
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Default widths of the per-window match count and the lost-window counter
  localparam int DEF_CNT_W  = 8;
  localparam int DEF_LOST_W = 4;

  // Detector output symbols: a match is reported as symbol 'c'
  typedef enum logic [0:0] {
    SYM_B = 1'b0,
    SYM_C = 1'b1
  } det_sym_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module   : sat_counter
//  Brief    : Up-counter that sticks at its maximum value; flags any
//             increment attempted while already saturated.
//  Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         sat_hit
);

  // Count up on inc, hold at all-ones; clear has priority
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc && !(&value)) begin
      value <= value + W'(1);
    end
  end

  // Increment requested while already at the ceiling
  assign sat_hit = inc & (&value);

endmodule
`default_nettype wire

// File: rtl/match_window_reporter.sv
`default_nettype none
// ============================================================================
//  Module   : match_window_reporter
//  Brief    : Counts detector matches over fixed windows of qualified
//             samples and publishes each window's count through a
//             single-entry valid/ready report slot, tracking windows lost
//             to back-pressure.
//  Revision : 1.0 - initial release
// ============================================================================
module match_window_reporter
  import pattern_pkg::*;
#(
  parameter int WIN_LEN = 16,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int LOST_W  = DEF_LOST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              smp_en,
  input  logic              det,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [CNT_W-1:0]  rpt_count,
  output logic              rpt_sat,
  output logic [LOST_W-1:0] rpt_lost,
  output logic              busy
);

  localparam int IDX_W = $clog2(WIN_LEN);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [IDX_W-1:0]    r_win_idx;
  logic                r_sat;
  logic [CNT_W-1:0]    w_hit_cnt;
  logic                w_hit_sat_hit;
  logic [CNT_W-1:0]    w_final_cnt;
  logic                w_final_sat;
  logic [LOST_W-1:0]   w_lost_acc;
  logic                w_lost_sat_unused;
  logic                w_run;
  logic                w_take;
  logic                w_hit;
  logic                w_end;
  logic                w_win_clr;
  logic                w_load;
  logic                w_drop;
  logic                r_rpt_valid;
  logic [CNT_W-1:0]    r_rpt_count;
  logic                r_rpt_sat;
  logic [LOST_W-1:0]   r_rpt_lost;

  // A sample is taken only in RUN and only when no start/stop is clearing
  // the window in the same cycle.
  assign w_run     = (r_state == ST_RUN);
  assign w_take    = w_run & smp_en & ~start & ~stop;
  assign w_hit     = w_take & (det_sym_t'(det) == SYM_C);
  assign w_end     = w_take & (r_win_idx == IDX_W'(WIN_LEN - 1));
  assign w_win_clr = start | stop | w_end;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: stop dominates a coincident start
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (start && !stop) w_state_nxt = ST_RUN;
      ST_RUN:  if (stop)           w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sample index within the current window, wrapping at the window end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_win_idx <= '0;
    end else if (start || stop) begin
      r_win_idx <= '0;
    end else if (w_take) begin
      r_win_idx <= w_end ? '0 : r_win_idx + IDX_W'(1);
    end
  end

  sat_counter #(.W(CNT_W)) u_hit_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_win_clr),
    .inc     (w_hit),
    .value   (w_hit_cnt),
    .sat_hit (w_hit_sat_hit)
  );

  // Sticky saturation flag for the window in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat <= 1'b0;
    end else if (w_win_clr) begin
      r_sat <= 1'b0;
    end else if (w_hit_sat_hit) begin
      r_sat <= 1'b1;
    end
  end

  // The final sample's hit is folded in combinationally so the report
  // carries the complete window one cycle after the last sample.
  assign w_final_cnt = w_hit_cnt + CNT_W'(w_hit & ~w_hit_sat_hit);
  assign w_final_sat = r_sat | w_hit_sat_hit;

  // Slot accepts a new report when empty or when being drained this cycle
  assign w_load = w_end & (~r_rpt_valid | rpt_ready);
  assign w_drop = w_end & r_rpt_valid & ~rpt_ready;

  sat_counter #(.W(LOST_W)) u_lost_acc (
    .clk     (clk),
    .rst     (rst),
    .clr     (w_load),
    .inc     (w_drop),
    .value   (w_lost_acc),
    .sat_hit (w_lost_sat_unused)
  );

  // Single-entry report slot; contents frozen while valid and unaccepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rpt_valid <= 1'b0;
      r_rpt_count <= '0;
      r_rpt_sat   <= 1'b0;
      r_rpt_lost  <= '0;
    end else if (w_load) begin
      r_rpt_valid <= 1'b1;
      r_rpt_count <= w_final_cnt;
      r_rpt_sat   <= w_final_sat;
      r_rpt_lost  <= w_lost_acc;
    end else if (r_rpt_valid && rpt_ready) begin
      r_rpt_valid <= 1'b0;
    end
  end

  assign rpt_valid = r_rpt_valid;
  assign rpt_count = r_rpt_count;
  assign rpt_sat   = r_rpt_sat;
  assign rpt_lost  = r_rpt_lost;
  assign busy      = w_run;

endmodule
`default_nettype wire

// File: tb/tb_match_window_reporter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_match_window_reporter
//  Brief    : Scoreboard bench for match_window_reporter (WIN_LEN=8,
//             CNT_W=3, LOST_W=2).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_match_window_reporter;

  localparam int WIN_LEN = 8;
  localparam int CNT_W   = 3;
  localparam int LOST_W  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic              smp_en;
  logic              det;
  logic              rpt_valid;
  logic              rpt_ready;
  logic [CNT_W-1:0]  rpt_count;
  logic              rpt_sat;
  logic [LOST_W-1:0] rpt_lost;
  logic              busy;

  typedef struct packed {
    logic [CNT_W-1:0]  count;
    logic              sat;
    logic [LOST_W-1:0] lost;
  } rpt_t;

  rpt_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;

  match_window_reporter #(
    .WIN_LEN (WIN_LEN),
    .CNT_W   (CNT_W),
    .LOST_W  (LOST_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .smp_en    (smp_en),
    .det       (det),
    .rpt_valid (rpt_valid),
    .rpt_ready (rpt_ready),
    .rpt_count (rpt_count),
    .rpt_sat   (rpt_sat),
    .rpt_lost  (rpt_lost),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input int c, input int s, input int l);
    rpt_t e;
    e.count = CNT_W'(c);
    e.sat   = s[0];
    e.lost  = LOST_W'(l);
    exp_q.push_back(e);
  endtask

  // One clock: score a transfer that happens on this edge, then advance
  task automatic step();
    rpt_t e;
    if (rpt_valid === 1'b1 && rpt_ready === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_report: got count=%0d sat=%0d lost=%0d, required no report",
                 rpt_count, rpt_sat, rpt_lost);
      end else begin
        e = exp_q.pop_front();
        if ({rpt_count, rpt_sat, rpt_lost} !== e) begin
          miscompares++;
          $display("FAIL report: got count=%0d sat=%0d lost=%0d, required count=%0d sat=%0d lost=%0d",
                   rpt_count, rpt_sat, rpt_lost, e.count, e.sat, e.lost);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic d);
    smp_en = 1'b1;
    det    = d;
    step();
    smp_en = 1'b0;
    det    = 1'b0;
  endtask

  task automatic window(input logic [WIN_LEN-1:0] hits);
    for (int i = 0; i < WIN_LEN; i++) sample(hits[i]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d reports outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; smp_en = 1'b0; det = 1'b0; rpt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({rpt_valid, busy, rpt_count, rpt_sat, rpt_lost} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%0b busy=%0b count=%0d sat=%0b lost=%0d, required all 0",
               rpt_valid, busy, rpt_count, rpt_sat, rpt_lost);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (rpt_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL after_reset_idle: got valid=%0b busy=%0b, required 0 0", rpt_valid, busy);
    end
  endtask

  task automatic test_basic();
    logic [WIN_LEN-1:0] h = 8'b0100_0010;
    rpt_ready = 1'b1;
    pulse_start();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL busy_after_start: got %0b, required 1", busy);
    end
    push_exp(2, 0, 0);
    for (int i = 0; i < WIN_LEN; i++) begin
      sample(h[i]);
      if (i < WIN_LEN - 1) begin
        vectors++;
        if (rpt_valid !== 1'b0) begin
          miscompares++;
          $display("FAIL early_valid: got valid=%0b at sample %0d, required 0", rpt_valid, i);
        end
      end
    end
    vectors++;
    if (rpt_valid !== 1'b1 || rpt_count !== 3'd2) begin
      miscompares++;
      $display("FAIL basic_latency: got valid=%0b count=%0d, required 1 2", rpt_valid, rpt_count);
    end
    step();
    vectors++;
    if (rpt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_one_cycle: got valid=%0b, required 0", rpt_valid);
    end
    drain();
  endtask

  task automatic test_sat_gating();
    push_exp(7, 1, 0);
    for (int i = 0; i < WIN_LEN; i++) begin
      det = 1'b1;
      step();
      sample(1'b1);
    end
    drain();
    push_exp(1, 0, 0);
    for (int i = 0; i < WIN_LEN; i++) begin
      det = 1'b1;
      step();
      sample(i == 3);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [WIN_LEN-1:0] h = 8'b0001_0001;
    rpt_ready = 1'b0;
    push_exp(2, 0, 0);
    window(h);
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < WIN_LEN; i++) begin
        sample(h[i]);
        vectors++;
        if (rpt_valid !== 1'b1 || rpt_count !== 3'd2 || rpt_lost !== 2'd0) begin
          miscompares++;
          $display("FAIL bp_hold: got valid=%0b count=%0d lost=%0d, required 1 2 0",
                   rpt_valid, rpt_count, rpt_lost);
        end
      end
    end
    rpt_ready = 1'b1;
    push_exp(2, 0, 3);
    step();
    for (int i = 0; i < WIN_LEN - 1; i++) sample(h[i]);
    rpt_ready = 1'b0;
    sample(h[WIN_LEN-1]);
    for (int w = 0; w < 5; w++) window(h);
    vectors++;
    if (rpt_valid !== 1'b1 || rpt_lost !== 2'd3 || rpt_count !== 3'd2) begin
      miscompares++;
      $display("FAIL bp_second_hold: got valid=%0b count=%0d lost=%0d, required 1 2 3",
               rpt_valid, rpt_count, rpt_lost);
    end
    rpt_ready = 1'b1;
    step();
    push_exp(2, 0, 3);
    window(h);
    drain();
  endtask

  task automatic test_back_to_back();
    logic [WIN_LEN-1:0] hb = 8'b1000_0101;
    rpt_ready = 1'b0;
    push_exp(1, 0, 0);
    window(8'b0000_1000);
    push_exp(3, 0, 0);
    for (int i = 0; i < WIN_LEN - 1; i++) begin
      sample(hb[i]);
      vectors++;
      if (rpt_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_hold: got valid=%0b, required 1", rpt_valid);
      end
    end
    rpt_ready = 1'b1;
    sample(hb[WIN_LEN-1]);
    vectors++;
    if (rpt_valid !== 1'b1 || rpt_count !== 3'd3 || rpt_lost !== 2'd0) begin
      miscompares++;
      $display("FAIL b2b_reload: got valid=%0b count=%0d lost=%0d, required 1 3 0",
               rpt_valid, rpt_count, rpt_lost);
    end
    drain();
  endtask

  task automatic test_stop_start();
    rpt_ready = 1'b1;
    for (int i = 0; i < 5; i++) sample(1'b1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL busy_after_stop: got %0b, required 0", busy);
    end
    for (int i = 0; i < 4; i++) sample(1'b1);
    vectors++;
    if (rpt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_no_report: got valid=%0b, required 0", rpt_valid);
    end
    pulse_start();
    push_exp(3, 0, 0);
    window(8'b0010_1001);
    drain();
    for (int i = 0; i < 3; i++) sample(1'b1);
    pulse_start();
    push_exp(1, 0, 0);
    window(8'b0100_0000);
    drain();
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL start_stop_same_cycle: got busy=%0b, required 0", busy);
    end
    for (int i = 0; i < WIN_LEN; i++) sample(1'b1);
    vectors++;
    if (rpt_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_after_both: got valid=%0b, required 0", rpt_valid);
    end
  endtask

  task automatic test_async_reset();
    logic [WIN_LEN-1:0] h = 8'b0001_0001;
    rpt_ready = 1'b0;
    pulse_start();
    window(h);
    window(h);
    vectors++;
    if (rpt_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL ar_pending: got valid=%0b, required 1", rpt_valid);
    end
    for (int i = 0; i < 3; i++) sample(1'b1);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if (rpt_valid !== 1'b0 || busy !== 1'b0 || rpt_count !== 3'd0) begin
      miscompares++;
      $display("FAIL async_reset: got valid=%0b busy=%0b count=%0d, required 0 0 0",
               rpt_valid, busy, rpt_count);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rpt_ready = 1'b1;
    pulse_start();
    push_exp(1, 0, 0);
    window(8'b0000_0010);
    drain();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sat_gating();
    test_backpressure();
    test_back_to_back();
    test_stop_start();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, required completion within bound");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
